pulse_period_meter: RTL and testbench

Measures the spacing of an incoming pulse train and reports it in the same "ticks" units the pulse generator takes as its period input. A stream from the pulse generator programmed with ticks = T reads back as period = T. Sits on the receive side of pulse-driven paths in the etch-a-sketch design, such as the input-rate check and generator loop-back self-test. It flags a timeout when no pulse arrives within the counter range.

---
 rtl/pulse_meter_pkg.sv | 14 +
 rtl/pulse_period_meter_if.sv | 37 +++
 rtl/comparator_eq.sv | 13 +
 rtl/edge_detector.sv | 28 ++
 rtl/pulse_period_meter.sv | 108 ++++++++++
 tb/tb_pulse_period_meter.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg
// Shared types and constants for the pulse period meter.
//   meter_state_t : measurement FSM state (S_IDLE, S_MEASURE)
//   DEFAULT_N     : default width of the interval counter / period output
package pulse_meter_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/pulse_period_meter_if.sv
// pulse_period_meter_if
// Bundles the measurement-side signals of the pulse period meter.
//   ena          : measurement enable (master -> meter)
//   pulse_in     : pulse train, synchronous to clk (master -> meter)
//   period       : last measured interval, held between updates (meter -> master)
//   period_valid : one-cycle strobe, period updated this cycle (meter -> master)
//   timeout      : one-cycle strobe, no rising edge within 2^N cycles (meter -> master)
// Signalling: there is no backpressure. ena/pulse_in are sampled every clock;
// period_valid and timeout are single-cycle strobes the consumer must take on
// the cycle they are high, and period stays stable until the next strobe.
interface pulse_period_meter_if
  import pulse_meter_pkg::*;
#(
  parameter int N = DEFAULT_N
);
  logic         ena;
  logic         pulse_in;
  logic [N-1:0] period;
  logic         period_valid;
  logic         timeout;

  modport master (
    output ena,
    output pulse_in,
    input  period,
    input  period_valid,
    input  timeout
  );

  modport slave (
    input  ena,
    input  pulse_in,
    output period,
    output period_valid,
    output timeout
  );
endinterface

// File: rtl/comparator_eq.sv
// comparator_eq
// Generic equality comparator.
//   i_a, i_b : W-bit operands
//   o_eq     : high when i_a == i_b
module comparator_eq #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq
);
  assign o_eq = (i_a == i_b);
endmodule

// File: rtl/edge_detector.sv
// edge_detector
// Rising-edge detector for the pulse train.
//   clk, rst : clock and synchronous active-high reset
//   i_pulse  : pulse input
//   i_ena    : enable; when low the edge output is forced to 0
//   o_edge   : i_pulse & ~pulse_prev, gated by i_ena
// pulse_prev tracks the input every cycle even while disabled, so raising
// enable on an already-high input never looks like an edge. It resets to 0,
// so an input that is high at reset release is reported as an edge.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic i_pulse,
  input  logic i_ena,
  output logic o_edge
);
  logic r_pulse_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pulse_prev <= 1'b0;
    end else begin
      r_pulse_prev <= i_pulse;
    end
  end

  assign o_edge = i_ena & i_pulse & ~r_pulse_prev;
endmodule

// File: rtl/pulse_period_meter.sv
// pulse_period_meter
// Measures the spacing between rising edges of a pulse train in generator
// "ticks" (edges c0, c1 give period = c1 - c0 - 1), and flags a timeout when
// no edge follows within 2^N cycles.
//   clk, rst    : clock and synchronous active-high reset
//   bus         : pulse_period_meter_if slave (ena, pulse_in in; period,
//                 period_valid, timeout out)
//   o_dbg_state : current FSM state, for observation only
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                  clk,
  input  logic                  rst,
  pulse_period_meter_if.slave   bus,
  output meter_state_t          o_dbg_state
);
  localparam logic [N-1:0] ALL_ONES = '1;

  meter_state_t r_state;
  meter_state_t w_state_nx;
  logic [N-1:0] r_count;
  logic [N-1:0] w_count_nx;
  logic [N-1:0] r_period;
  logic [N-1:0] w_period_nx;
  logic         r_valid;
  logic         w_valid_nx;
  logic         r_timeout;
  logic         w_timeout_nx;
  logic         w_edge;
  logic         w_sat;

  edge_detector u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_pulse (bus.pulse_in),
    .i_ena   (bus.ena),
    .o_edge  (w_edge)
  );

  // Counter has reached its last representable value; one more empty
  // cycle means the interval is out of range.
  comparator_eq #(.W(N)) u_sat_cmp (
    .i_a  (r_count),
    .i_b  (ALL_ONES),
    .o_eq (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_period  <= w_period_nx;
      r_valid   <= w_valid_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  // w_edge is already gated by ena, so an edge seen here is always a live one.
  always_comb begin
    w_state_nx   = r_state;
    w_count_nx   = r_count;
    w_period_nx  = r_period;
    w_valid_nx   = 1'b0;
    w_timeout_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_count_nx = '0;
        if (w_edge) begin
          w_state_nx = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (!bus.ena) begin
          w_state_nx = S_IDLE;
          w_count_nx = '0;
        end else if (w_edge) begin
          // Edge wins over saturation: an interval of exactly 2^N-1 is valid.
          w_period_nx = r_count;
          w_valid_nx  = 1'b1;
          w_count_nx  = '0;
        end else if (w_sat) begin
          w_timeout_nx = 1'b1;
          w_count_nx   = '0;
          w_state_nx   = S_IDLE;
        end else begin
          w_count_nx = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_count_nx = '0;
      end
    endcase
  end

  assign bus.period       = r_period;
  assign bus.period_valid = r_valid;
  assign bus.timeout      = r_timeout;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter
// Self-checking bench for pulse_period_meter (N = 8): directed scenarios plus
// randomized pulse trains, checked cycle by cycle against a timestamp model.
module tb_pulse_period_meter;
  import pulse_meter_pkg::*;

  localparam int N    = 8;
  localparam int SPAN = 1 << N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_period_meter_if #(.N(N)) bus ();
  meter_state_t dbg_state;

  pulse_period_meter #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_timeout = 0;
  int last_to_cyc = -1;
  logic [N-1:0] last_valid_period = '0;
  logic [N-1:0] exp_q[$];

  // Reference model: remembers when the last accepted edge happened and
  // whether a measurement is armed; intervals are plain timestamp differences.
  logic         m_prev   = 1'b0;
  logic         m_armed  = 1'b0;
  int           m_last   = 0;
  logic [N-1:0] m_period = '0;
  logic         m_valid  = 1'b0;
  logic         m_to     = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d required %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic p);
    logic edge_seen;
    if (r) begin
      m_prev = 1'b0; m_armed = 1'b0; m_period = '0; m_valid = 1'b0; m_to = 1'b0;
    end else begin
      edge_seen = p && !m_prev;
      m_prev  = p;
      m_valid = 1'b0;
      m_to    = 1'b0;
      if (!e) begin
        m_armed = 1'b0;
      end else if (edge_seen) begin
        if (m_armed) begin
          m_period = N'(cyc - m_last - 1);
          m_valid  = 1'b1;
          exp_q.push_back(m_period);
        end
        m_armed = 1'b1;
        m_last  = cyc;
      end else if (m_armed && (cyc - m_last == SPAN)) begin
        m_to    = 1'b1;
        m_armed = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic e, input logic p);
    logic [N-1:0] exp_p;
    rst = r; bus.ena = e; bus.pulse_in = p;
    model_step(r, e, p);
    @(posedge clk); #1;
    cyc++;
    check_eq("period_valid", 32'(bus.period_valid), 32'(m_valid));
    check_eq("timeout", 32'(bus.timeout), 32'(m_to));
    check_eq("period", 32'(bus.period), 32'(m_period));
    check_eq("state", 32'(dbg_state), 32'(m_armed));
    if (bus.period_valid) begin
      n_valid++;
      last_valid_period = bus.period;
      check_eq("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_p = exp_q.pop_front();
        check_eq("q_period", 32'(bus.period), 32'(exp_p));
      end
    end
    if (bus.timeout) begin
      n_timeout++;
      last_to_cyc = cyc;
    end
  endtask

  task automatic idle_gap();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_valid = 0; n_timeout = 0;
  endtask

  task automatic pulse_train(input int cycles, input int spacing, input int width);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, (i % spacing) < width);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int thresh_tab[5] = '{0, 1, 5, 30, 60};
    int th;
    bus.ena = 1'b0; bus.pulse_in = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("rst_period", 32'(bus.period), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // Loop-back: generator ticks = 9 -> edge every 10 cycles
    idle_gap();
    pulse_train(60, 10, 1);
    check_eq("loop_nvalid", 32'(n_valid), 32'd5);
    check_eq("loop_period", 32'(last_valid_period), 32'd9);
    check_eq("loop_ntimeout", 32'(n_timeout), 32'd0);

    // Wide pulses: 3 cycles high, edges 20 apart
    idle_gap();
    pulse_train(100, 20, 3);
    check_eq("wide_nvalid", 32'(n_valid), 32'd4);
    check_eq("wide_period", 32'(last_valid_period), 32'd19);

    // Upper range limit: edges 256 apart -> 255, no timeout
    idle_gap();
    pulse_train(520, 256, 1);
    check_eq("max_nvalid", 32'(n_valid), 32'd2);
    check_eq("max_period", 32'(last_valid_period), 32'd255);
    check_eq("max_ntimeout", 32'(n_timeout), 32'd0);

    // Single edge then silence -> timeout at c0 + 257, period held at 255
    idle_gap();
    c0 = cyc;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
    check_eq("to_count", 32'(n_timeout), 32'd1);
    check_eq("to_latency", 32'(last_to_cyc - c0), 32'(SPAN + 1));
    check_eq("to_period_held", 32'(bus.period), 32'd255);
    check_eq("to_state", 32'(dbg_state), 32'(S_IDLE));

    // Minimum pattern 1,0,1 -> period 1
    idle_gap();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check_eq("min_period", 32'(last_valid_period), 32'd1);
    check_eq("min_nvalid", 32'(n_valid), 32'd1);

    // ena drop for 5 cycles with one edge inside the window
    idle_gap();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check_eq("ena_off_nvalid", 32'(n_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("ena_nvalid", 32'(n_valid), 32'd1);
    check_eq("ena_period", 32'(last_valid_period), 32'd6);

    // Reset with counter = 40, pulse_in high at release
    idle_gap();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_eq("midrst_period", 32'(bus.period), 32'd0);
    check_eq("midrst_valid", 32'(bus.period_valid), 32'd0);
    check_eq("midrst_timeout", 32'(bus.timeout), 32'd0);
    check_eq("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    n_valid = 0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check_eq("rel_nvalid", 32'(n_valid), 32'd1);
    check_eq("rel_period", 32'(last_valid_period), 32'd14);

    // Randomized pulse trains with enable drops and occasional resets
    for (int b = 0; b < 12; b++) begin
      th = thresh_tab[$urandom_range(0, 4)];
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 499) == 0,
             $urandom_range(0, 39) != 0,
             $urandom_range(0, 99) < th);
      end
    end
    // Long quiet stretch so any armed measurement ends in a timeout
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);

    check_eq("q_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
